// File: rtl/tdl_pkg.sv
// Shared sizing helpers and default parameters for the multi-channel tapped delay line.
package tdl_pkg;

    localparam int TDL_WIDTH    = 16;
    localparam int TDL_DEPTH    = 4;
    localparam int TDL_CHANNELS = 2;

    // Channel index width; a single channel still needs a one-bit field.
    function automatic int chw(input int n);
        int w;
        w = (n > 1) ? $clog2(n) : 1;
        return w;
    endfunction

    function automatic int fillw(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/tdl_channel_bank.sv
// One channel of history: DEPTH-entry shift register plus a saturating fill counter.
module tdl_channel_bank
    import tdl_pkg::*;
#(
    parameter int WIDTH = TDL_WIDTH,
    parameter int DEPTH = TDL_DEPTH
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           clear,
    input  logic                           shift_en,
    input  logic [WIDTH-1:0]               in_data,
    output logic [DEPTH-1:0][WIDTH-1:0]    taps,
    output logic [fillw(DEPTH)-1:0]        fill
);

    localparam int FW = fillw(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] taps_r;
    logic [FW-1:0]               fill_r;

    // History shift (index 0 newest) and saturating fill count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            taps_r <= '0;
            fill_r <= '0;
        end else if (clear) begin
            taps_r <= '0;
            fill_r <= '0;
        end else if (shift_en) begin
            taps_r[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                taps_r[i] <= taps_r[i-1];
            end
            if (fill_r != FW'(DEPTH)) begin
                fill_r <= fill_r + FW'(1);
            end
        end
    end

    assign taps = taps_r;
    assign fill = fill_r;

endmodule

// File: rtl/mc_tapped_delay_line.sv
// Multi-channel tapped delay line: interleaved input, per-channel history, registered tap-vector output.
// Optional build macro TDL_PRIME_EN gates output until the written channel holds DEPTH samples.
module mc_tapped_delay_line
    import tdl_pkg::*;
#(
    parameter int WIDTH    = TDL_WIDTH,
    parameter int DEPTH    = TDL_DEPTH,
    parameter int CHANNELS = TDL_CHANNELS
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [chw(CHANNELS)-1:0]       out_ch,
    output logic [DEPTH-1:0][WIDTH-1:0]    out_taps,
    output logic [fillw(DEPTH)-1:0]        out_fill
);

    localparam int CH_W = chw(CHANNELS);
    localparam int FW   = fillw(DEPTH);

    logic [CH_W-1:0]               ch_ptr_r;
    logic                          out_valid_r;
    logic [CH_W-1:0]               out_ch_r;
    logic [DEPTH-1:0][WIDTH-1:0]   out_taps_r;
    logic [FW-1:0]                 out_fill_r;

    logic                          in_ready_s;
    logic                          accept_s;
    logic                          load_s;
    logic [CHANNELS-1:0]           shift_en_s;
    logic [DEPTH-1:0][WIDTH-1:0]   bank_taps_s [CHANNELS];
    logic [FW-1:0]                 bank_fill_s [CHANNELS];
    logic [DEPTH-1:0][WIDTH-1:0]   sel_taps_s;
    logic [FW-1:0]                 sel_fill_s;
    logic [DEPTH-1:0][WIDTH-1:0]   nxt_taps_s;
    logic [FW-1:0]                 nxt_fill_s;
    logic [CH_W-1:0]               nxt_ptr_s;

    assign in_ready_s = !clear && (!out_valid_r || out_ready);
    assign accept_s   = in_valid && in_ready_s;

    // Select the active channel's history and form its post-shift view.
    always_comb begin
        sel_taps_s = '0;
        sel_fill_s = '0;
        shift_en_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_ptr_r == CH_W'(c)) begin
                sel_taps_s    = bank_taps_s[c];
                sel_fill_s    = bank_fill_s[c];
                shift_en_s[c] = accept_s;
            end else begin
                shift_en_s[c] = 1'b0;
            end
        end
        nxt_taps_s[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            nxt_taps_s[i] = sel_taps_s[i-1];
        end
        if (sel_fill_s == FW'(DEPTH)) begin
            nxt_fill_s = sel_fill_s;
        end else begin
            nxt_fill_s = sel_fill_s + FW'(1);
        end
        if (ch_ptr_r == CH_W'(CHANNELS - 1)) begin
            nxt_ptr_s = '0;
        end else begin
            nxt_ptr_s = ch_ptr_r + CH_W'(1);
        end
    end

`ifdef TDL_PRIME_EN
    // Priming: history still updates, but only a full channel presents a vector.
    assign load_s = accept_s && (nxt_fill_s == FW'(DEPTH));
`else
    assign load_s = accept_s;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_bank
        tdl_channel_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_bank (
            .clk      (clk),
            .rstn     (rstn),
            .clear    (clear),
            .shift_en (shift_en_s[c]),
            .in_data  (in_data),
            .taps     (bank_taps_s[c]),
            .fill     (bank_fill_s[c])
        );
    end

    // Channel pointer: advances on each accept, returns to 0 on flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch_ptr_r <= '0;
        end else if (clear) begin
            ch_ptr_r <= '0;
        end else if (accept_s) begin
            ch_ptr_r <= nxt_ptr_s;
        end
    end

    // Output register: flush drops the pending vector; consumption without reload empties it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            out_taps_r  <= '0;
            out_fill_r  <= '0;
        end else if (clear) begin
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            out_taps_r  <= '0;
            out_fill_r  <= '0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_ch_r    <= ch_ptr_r;
            out_taps_r  <= nxt_taps_s;
            out_fill_r  <= nxt_fill_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_ch    = out_ch_r;
    assign out_taps  = out_taps_r;
    assign out_fill  = out_fill_r;

endmodule

// File: tb/tb_mc_tapped_delay_line.sv
// Self-checking bench for mc_tapped_delay_line (WIDTH=16, DEPTH=4, CHANNELS=2), scoreboard driven.
module tb_mc_tapped_delay_line;

`ifdef TDL_PRIME_EN
    localparam bit PRIME = 1'b1;
`else
    localparam bit PRIME = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [15:0]          in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [0:0]           out_ch;
    logic [3:0][15:0]     out_taps;
    logic [2:0]           out_fill;

    always #5 clk = ~clk;

    mc_tapped_delay_line #(.WIDTH(16), .DEPTH(4), .CHANNELS(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_taps  (out_taps),
        .out_fill  (out_fill)
    );

    typedef struct {
        logic [63:0] ch;
        logic [63:0] taps;
        logic [63:0] fill;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] hist [2][4];
    int          fill [2];
    int          ptr;
    bit          m_valid;
    exp_t        cur;
    exp_t        q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            fill[c] = 0;
            for (int i = 0; i < 4; i++) hist[c][i] = 16'h0000;
        end
        ptr     = 0;
        m_valid = 1'b0;
        q.delete();
    endtask

    // One clock of stimulus; the model predicts handshake and output independently of the DUT.
    task automatic step(input logic v, input logic [15:0] d, input logic r, input logic c);
        bit   exp_ready;
        bit   load;
        exp_t e;
        load = 1'b0;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        #1;
        exp_ready = !c && (!m_valid || r);
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        if (c) begin
            model_reset();
        end else if (v && exp_ready) begin
            for (int i = 3; i > 0; i--) hist[ptr][i] = hist[ptr][i-1];
            hist[ptr][0] = d;
            if (fill[ptr] < 4) fill[ptr]++;
            if (!PRIME || fill[ptr] == 4) begin
                e.ch   = 64'(ptr);
                e.fill = 64'(fill[ptr]);
                for (int i = 0; i < 4; i++) e.taps[i*16 +: 16] = hist[ptr][i];
                q.push_back(e);
                load = 1'b1;
            end
            ptr = (ptr + 1) % 2;
        end
        @(posedge clk);
        #1;
        if (c) begin
            m_valid = 1'b0;
        end else if (load && q.size() > 0) begin
            cur     = q.pop_front();
            m_valid = 1'b1;
        end else if (r) begin
            m_valid = 1'b0;
        end
        check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        if (m_valid) begin
            check("out_ch", {63'd0, out_ch}, cur.ch);
            check("out_taps", out_taps, cur.taps);
            check("out_fill", {61'd0, out_fill}, cur.fill);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_ch", {63'd0, out_ch}, 64'd0);
        check("rst_out_taps", out_taps, 64'd0);
        check("rst_out_fill", {61'd0, out_fill}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Interleave 0x0001..0x0008, with fixed expectations at key points
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 16'(k), 1'b1, 1'b0);
            if (!PRIME && k == 5) begin
                check("il5_ch", {63'd0, out_ch}, 64'd0);
                check("il5_taps", out_taps, 64'h0000_0001_0003_0005);
            end
            if (!PRIME && k == 6) begin
                check("il6_ch", {63'd0, out_ch}, 64'd1);
                check("il6_taps", out_taps, 64'h0000_0002_0004_0006);
                check("il6_fill", {61'd0, out_fill}, 64'd3);
            end
            if (PRIME && k == 6) check("pr6_valid", {63'd0, out_valid}, 64'd0);
            if (PRIME && k == 7) begin
                check("pr7_valid", {63'd0, out_valid}, 64'd1);
                check("pr7_ch", {63'd0, out_ch}, 64'd0);
                check("pr7_taps", out_taps, 64'h0001_0003_0005_0007);
                check("pr7_fill", {61'd0, out_fill}, 64'd4);
            end
            if (PRIME && k == 8) begin
                check("pr8_ch", {63'd0, out_ch}, 64'd1);
                check("pr8_taps", out_taps, 64'h0002_0004_0006_0008);
            end
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure: stall four cycles after the first accept, then resume on ch1
        step(1'b0, 16'h0000, 1'b1, 1'b1);
        step(1'b1, 16'hA001, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 16'hB000 + 16'(k), 1'b0, 1'b0);
        step(1'b1, 16'hA002, 1'b1, 1'b0);
        step(1'b1, 16'hA003, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Clear mid-stream with a competing sample
        for (int k = 0; k < 3; k++) step(1'b1, 16'hC000 + 16'(k), 1'b1, 1'b0);
        step(1'b1, 16'hDEAD, 1'b1, 1'b1);
        step(1'b1, 16'hC100, 1'b1, 1'b0);
        if (!PRIME) begin
            check("clr_ch", {63'd0, out_ch}, 64'd0);
            check("clr_taps", out_taps, 64'h0000_0000_0000_C100);
            check("clr_fill", {61'd0, out_fill}, 64'd1);
        end

        // Saturation: ten samples per channel
        for (int k = 0; k < 20; k++) step(1'b1, 16'h5000 + 16'(k), 1'b1, 1'b0);
        check("sat_fill", {61'd0, out_fill}, 64'd4);
        check("sat_taps", out_taps, 64'h500D_500F_5011_5013);

        // Asynchronous reset mid-transfer
        step(1'b1, 16'h7777, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_out_taps", out_taps, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rstn = 1'b1;

        // Random traffic with stalls and occasional flushes
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
